// File: rtl/router_pkt_if.sv
// router_pkt_if: beat-level bus between the router input port, the packet
// register and the selected channel FIFO.
//
// Handshake: a beat on data_in/pkt_valid is taken on a rising clock edge
// whenever busy is low during that cycle; while busy is high the source holds
// data_in and pkt_valid unchanged. write_enb qualifies dout for exactly one
// cycle per beat, and the FIFO only sees it while fifo_full is low.
interface router_pkt_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic [DW-1:0] dout;
  logic          write_enb;
  logic [AW-1:0] dest;
  logic          busy;
  logic          parity_done;
  logic          err;
  logic          len_err;
  logic          drop;

  // Source / FIFO side
  modport master (
    output pkt_valid, data_in, fifo_full,
    input  dout, write_enb, dest, busy, parity_done, err, len_err, drop
  );

  // Packet register side
  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output dout, write_enb, dest, busy, parity_done, err, len_err, drop
  );
endinterface

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: decodes the header beat, forwards header/payload/parity
// beats to the FIFO write bus through a one-beat skid register, accumulates
// XOR parity and reports parity, length and address errors.
//
// Optional feature macro: ROUTER_LEN_CHECK_EN builds the payload counter and
// the length compare; without it len_err is tied low.
//
// The header is decoded in the IDLE cycle that sees pkt_valid=1, so the
// header is accepted in its first cycle and busy is only high in DONE or
// while the skid register holds a beat.
module router_pkt_reg #(
  parameter int DW     = 8,
  parameter int AW     = 2,
  parameter int NUM_CH = 3
) (
  input  logic       clock,
  input  logic       resetn,
  router_pkt_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int LW = DW - AW;
  localparam logic [AW:0] NUM_CH_W = NUM_CH[AW:0];

  typedef enum logic [1:0] {IDLE, PAY, DONE, DROP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          we_q, we_d;
  logic [AW-1:0] dest_q, dest_d;
  logic          busy_q, busy_d;
  logic          pd_q, pd_d;
  logic          err_q, err_d;
  logic          drop_q, drop_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          hold_v_q, hold_v_d;
  logic [DW-1:0] par_q, par_d;
  logic [DW-1:0] rx_q, rx_d;
`ifdef ROUTER_LEN_CHECK_EN
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          len_err_q, len_err_d;
`endif

  logic accept;
  logic fwd;

  // Next-state logic: FSM, skid register, parity/length tracking
  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    we_d     = 1'b0;
    dest_d   = dest_q;
    pd_d     = pd_q;
    err_d    = err_q;
    drop_d   = 1'b0;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    par_d    = par_q;
    rx_d     = rx_q;
    fwd      = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_err_d = len_err_q;
`endif

    // A beat is sampled only when not stalled; IDLE only takes a header.
    accept = !busy_q && ((state_q == IDLE) ? bus.pkt_valid
                                            : (state_q == PAY || state_q == DROP));

    // Drain the skid register as soon as the FIFO has room.
    if (hold_v_q && !bus.fifo_full) begin
      dout_d   = hold_q;
      we_d     = 1'b1;
      hold_v_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if ({1'b0, bus.data_in[AW-1:0]} < NUM_CH_W) begin
            dest_d = bus.data_in[AW-1:0];
            pd_d   = 1'b0;
            err_d  = 1'b0;
            par_d  = bus.data_in;
            fwd    = 1'b1;
`ifdef ROUTER_LEN_CHECK_EN
            len_d     = bus.data_in[DW-1:AW];
            cnt_d     = '0;
            len_err_d = 1'b0;
`endif
            state_d = PAY;
          end else begin
            state_d = DROP;
          end
        end
      end
      PAY: begin
        if (accept) begin
          fwd = 1'b1;
          if (bus.pkt_valid) begin
            par_d = par_q ^ bus.data_in;
`ifdef ROUTER_LEN_CHECK_EN
            if (cnt_q != {LW{1'b1}}) cnt_d = cnt_q + {{(LW-1){1'b0}}, 1'b1};
`endif
          end else begin
            rx_d    = bus.data_in;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        pd_d  = 1'b1;
        err_d = (rx_q != par_q);
`ifdef ROUTER_LEN_CHECK_EN
        len_err_d = (cnt_q != len_q);
`endif
        state_d = IDLE;
      end
      DROP: begin
        if (accept && !bus.pkt_valid) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Forwarded beat goes straight out, or into the skid register if full.
    if (fwd) begin
      if (bus.fifo_full) begin
        hold_d   = bus.data_in;
        hold_v_d = 1'b1;
      end else begin
        dout_d = bus.data_in;
        we_d   = 1'b1;
      end
    end

    busy_d = (state_d == DONE) || hold_v_d;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      we_q     <= 1'b0;
      dest_q   <= '0;
      busy_q   <= 1'b0;
      pd_q     <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      par_q    <= '0;
      rx_q     <= '0;
`ifdef ROUTER_LEN_CHECK_EN
      cnt_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      we_q     <= we_d;
      dest_q   <= dest_d;
      busy_q   <= busy_d;
      pd_q     <= pd_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      par_q    <= par_d;
      rx_q     <= rx_d;
`ifdef ROUTER_LEN_CHECK_EN
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
`endif
    end
  end

  assign bus.dout        = dout_q;
  assign bus.write_enb   = we_q;
  assign bus.dest        = dest_q;
  assign bus.busy        = busy_q;
  assign bus.parity_done = pd_q;
  assign bus.err         = err_q;
  assign bus.drop        = drop_q;
`ifdef ROUTER_LEN_CHECK_EN
  assign bus.len_err     = len_err_q;
`else
  assign bus.len_err     = 1'b0;
`endif
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg: directed test of router_pkt_reg (DW=8, AW=2, NUM_CH=3).
module tb_router_pkt_reg;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NUM_CH = 3;

`ifdef ROUTER_LEN_CHECK_EN
  localparam logic SHORT_LEN_ERR = 1'b1;
`else
  localparam logic SHORT_LEN_ERR = 1'b0;
`endif

  // Correct parity of header 0x0D and payload 0x11,0x22,0x33 is 0x0D.
  localparam logic [DW-1:0] PAR_FULL  = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
  localparam logic [DW-1:0] PAR_SHORT = 8'h0D ^ 8'h11 ^ 8'h22;

  logic       clock;
  logic       resetn;
  logic [1:0] dbg_state;

  router_pkt_if #(.DW(DW), .AW(AW)) bus ();

  router_pkt_reg #(.DW(DW), .AW(AW), .NUM_CH(NUM_CH)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every FIFO write must match the next expected beat
  always @(negedge clock) begin
    if (bus.write_enb === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) check("unexpected_write", 32'(bus.dout), 32'hDEAD_BEEF);
      else check("fifo_write_data", 32'(bus.dout), 32'(exp_q.pop_front()));
    end
  end

  // Driver: present a beat, hold it while busy, return just after the accepting edge
  task automatic send(input logic v, input logic [DW-1:0] d, input bit fwd);
    int n;
    n = 0;
    @(negedge clock);
    bus.pkt_valid = v;
    bus.data_in   = d;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      check("send_busy_timeout", 32'(n), 32'd0);
    end else begin
      @(posedge clock);
      if (fwd) exp_q.push_back(d);
      #1;
    end
  endtask

  // After the parity beat: one DONE cycle with busy, then flags
  task automatic check_done(input logic exp_err, input logic exp_len_err);
    @(negedge clock);
    check("done_busy", 32'(bus.busy), 32'd1);
    @(negedge clock);
    check("parity_done", 32'(bus.parity_done), 32'd1);
    check("err", 32'(bus.err), 32'(exp_err));
    check("len_err", 32'(bus.len_err), 32'(exp_len_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, 32'(bus.dout), 32'd0);
    check({tag, "_write_enb"}, 32'(bus.write_enb), 32'd0);
    check({tag, "_dest"}, 32'(bus.dest), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_parity_done"}, 32'(bus.parity_done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_len_err"}, 32'(bus.len_err), 32'd0);
    check({tag, "_drop"}, 32'(bus.drop), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  int wr_before;

  initial begin
    // Reset
    resetn        = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1 resetn = 1'b1;

    // Good packet: dest 1, len 3
    send(1'b1, 8'h0D, 1'b1);
    send(1'b1, 8'h11, 1'b1);
    send(1'b1, 8'h22, 1'b1);
    send(1'b1, 8'h33, 1'b1);
    send(1'b0, PAR_FULL, 1'b1);
    check_done(1'b0, 1'b0);
    check("good_dest", 32'(bus.dest), 32'd1);
    check("good_writes", 32'(wr_count), 32'd5);

    // Same packet with wrong parity
    send(1'b1, 8'h0D, 1'b1);
    send(1'b1, 8'h11, 1'b1);
    send(1'b1, 8'h22, 1'b1);
    send(1'b1, 8'h33, 1'b1);
    send(1'b0, 8'hFF, 1'b1);
    check_done(1'b1, 1'b0);

    // Short packet: two payload beats against a length of 3
    send(1'b1, 8'h0D, 1'b1);
    send(1'b1, 8'h11, 1'b1);
    send(1'b1, 8'h22, 1'b1);
    send(1'b0, PAR_SHORT, 1'b1);
    check_done(1'b0, SHORT_LEN_ERR);

    // FIFO full for four cycles around payload 0x22
    send(1'b1, 8'h0D, 1'b1);
    send(1'b1, 8'h11, 1'b1);
    bus.fifo_full = 1'b1;
    send(1'b1, 8'h22, 1'b1);
    repeat (3) begin
      @(negedge clock);
      check("stall_busy", 32'(bus.busy), 32'd1);
      check("stall_no_write", 32'(bus.write_enb), 32'd0);
    end
    @(posedge clock);
    #1 bus.fifo_full = 1'b0;
    @(negedge clock);
    check("drain_cycle_busy", 32'(bus.busy), 32'd1);
    @(posedge clock);
    #1;
    send(1'b1, 8'h33, 1'b1);
    send(1'b0, PAR_FULL, 1'b1);
    check_done(1'b0, 1'b0);

    // Invalid destination 3: consumed, not forwarded, flags untouched
    wr_before = wr_count;
    send(1'b1, 8'h07, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    send(1'b0, 8'h52, 1'b0);
    @(negedge clock);
    check("drop_pulse", 32'(bus.drop), 32'd1);
    @(negedge clock);
    check("drop_one_cycle", 32'(bus.drop), 32'd0);
    check("drop_keeps_parity_done", 32'(bus.parity_done), 32'd1);
    check("drop_keeps_dest", 32'(bus.dest), 32'd1);
    check("drop_no_writes", 32'(wr_count), 32'(wr_before));

    // Reset in the middle of a payload
    send(1'b1, 8'h06, 1'b1);
    send(1'b1, 8'h11, 1'b1);
    @(negedge clock);
    resetn        = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    check_all_zero("midreset");
    check("midreset_sb_empty", 32'(exp_q.size()), 32'd0);

    // Fresh packet after reset: dest 2, len 1
    send(1'b1, 8'h06, 1'b1);
    send(1'b1, 8'hA5, 1'b1);
    send(1'b0, 8'h06 ^ 8'hA5, 1'b1);
    check_done(1'b0, 1'b0);
    check("fresh_dest", 32'(bus.dest), 32'd2);

    // Zero-length packet to dest 0
    send(1'b1, 8'h00, 1'b1);
    send(1'b0, 8'h00, 1'b1);
    check_done(1'b0, 1'b0);
    check("zero_len_dest", 32'(bus.dest), 32'd0);

    @(negedge clock);
    check("total_writes", 32'(wr_count), 32'd26);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
